fpu_seq_ctrl: RTL and testbench

FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

---
 rtl/fpu_seq_ctrl_if.sv | 22 ++
 rtl/fpu_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_fpu_seq_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_ctrl_if.sv
// FP ALU bus between the sequencer (master) and the floating-point ALU (slave).
// Handshake: alu_start is a one-cycle request. alu_done is a one-cycle completion.
// alu_result/alu_flags are valid only while alu_done=1. Operands are driven continuously.
interface fpu_seq_ctrl_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [4:0]  alu_flags;

    modport master (
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_done, alu_result, alu_flags
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_done, alu_result, alu_flags
    );
endinterface

// File: rtl/fpu_seq_ctrl.sv
// Push-button sequencer that loads FP ALU operands from switches, runs one op and shows the result.
// Define FPU_SEQ_DEBOUNCE_EN to insert a DB_CYC-cycle stability filter after the btnC synchronizer.
module fpu_seq_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int DB_CYC      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btnC,
    input  logic [15:0]           sw,
    fpu_seq_ctrl_if.master        alu,
    output logic [31:0]           result,
    output logic [4:0]            flags,
    output logic                  timeout_err,
    output logic [2:0]            state,
    output logic                  busy
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || DB_CYC < 1) begin : g_cfg_check
        $error("fpu_seq_ctrl: TIMEOUT_CYC must be 1..255 and DB_CYC >= 1");
    end

    typedef enum logic [2:0] {
        LD_AL = 3'd0, LD_AH = 3'd1, LD_BL = 3'd2, LD_BH = 3'd3,
        LD_OP = 3'd4, EXEC  = 3'd5, WAIT  = 3'd6, SHOW  = 3'd7
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic        sync1, sync2;
    logic [1:0]  sync_vld;
    logic        armed;
    logic        lvl, lvl_q;
    logic        press;
    logic        timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            sync1    <= btnC;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

`ifdef FPU_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYC + 1);
    logic [DB_W-1:0] db_cnt;
    logic            filt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
            filt   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    // A button held across reset release must not count: presses are accepted only
    // after the synchronized input has been seen low with real (post-reset) data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            lvl_q <= lvl;
            armed <= armed | (sync_vld[1] & ~sync2);
        end
    end

    assign press       = lvl & ~lvl_q & armed;
    assign timeout_hit = (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= LD_AL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_AL: if (press) state_d = LD_AH;
            LD_AH: if (press) state_d = LD_BL;
            LD_BL: if (press) state_d = LD_BH;
            LD_BH: if (press) state_d = LD_OP;
            LD_OP: if (press) state_d = EXEC;
            EXEC:  state_d = WAIT;
            WAIT:  if (alu.alu_done || timeout_hit) state_d = SHOW;
            SHOW:  if (press) state_d = LD_AL;
            default: state_d = LD_AL;
        endcase
    end

    always_comb begin
        alu.alu_start = (state_q == EXEC);
        busy          = (state_q == EXEC) || (state_q == WAIT);
        state         = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu.alu_a  <= '0;
            alu.alu_b  <= '0;
            alu.alu_op <= '0;
        end else if (press) begin
            case (state_q)
                LD_AL:   alu.alu_a[15:0]  <= sw;
                LD_AH:   alu.alu_a[31:16] <= sw;
                LD_BL:   alu.alu_b[15:0]  <= sw;
                LD_BH:   alu.alu_b[31:16] <= sw;
                LD_OP:   alu.alu_op       <= sw[1:0];
                default: ;
            endcase
        end
    end

    // The counter is only nonzero inside WAIT; EXEC always precedes WAIT, so entry sees 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                wait_cnt <= '0;
        else if (state_q != WAIT)  wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 8'd1;
    end

    // alu_done wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result      <= '0;
            flags       <= '0;
            timeout_err <= 1'b0;
        end else if (state_q == WAIT) begin
            if (alu.alu_done) begin
                result      <= alu.alu_result;
                flags       <= alu.alu_flags;
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Self-checking bench for fpu_seq_ctrl: table vectors, random operations against a
// transaction-level reference model, and hand-written reset/spurious/press corner cases.
module tb_fpu_seq_ctrl;

  localparam int TO = 8;
`ifdef FPU_SEQ_DEBOUNCE_EN
  localparam int HOLD = 6;
  localparam int LAT  = 6;
`else
  localparam int HOLD = 1;
  localparam int LAT  = 2;
`endif
  localparam int EXP_W = 104;

  typedef struct {
    logic [4:0][15:0] sw;
    int               lat;
    logic [31:0]      res;
    logic [4:0]       fl;
    logic [31:0]      e_a;
    logic [31:0]      e_b;
    logic [1:0]       e_op;
    logic [31:0]      e_res;
    logic [4:0]       e_fl;
    logic             e_to;
    int               e_wait;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        btnC = 1'b0;
  logic [15:0] sw = '0;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        timeout_err;
  logic [2:0]  state;
  logic        busy;

  fpu_seq_ctrl_if bus();

  logic        model_done;
  logic [31:0] model_res;
  logic [4:0]  model_fl;
  logic        spur_done = 1'b0;
  logic [31:0] spur_res = '0;
  logic [4:0]  spur_fl = '0;
  int          cur_lat = 0;
  logic [31:0] cur_res = '0;
  logic [4:0]  cur_fl = '0;

  assign bus.alu_done   = model_done | spur_done;
  assign bus.alu_result = spur_done ? spur_res : model_res;
  assign bus.alu_flags  = spur_done ? spur_fl : model_fl;

  fpu_seq_ctrl #(.TIMEOUT_CYC(TO), .DB_CYC(4)) dut (
    .clk(clk),
    .reset(reset),
    .btnC(btnC),
    .sw(sw),
    .alu(bus),
    .result(result),
    .flags(flags),
    .timeout_err(timeout_err),
    .state(state),
    .busy(busy)
  );

  // ALU model: answers cur_lat cycles after the start cycle (0 = never), junk otherwise.
  initial begin
    model_done = 1'b0;
    model_res  = $urandom;
    model_fl   = 5'($urandom);
    forever begin
      @(negedge clk);
      if (bus.alu_start && cur_lat != 0) begin
        repeat (cur_lat) @(posedge clk);
        #1 model_done = 1'b1;
        model_res = cur_res;
        model_fl  = cur_fl;
        @(posedge clk);
        #1 model_done = 1'b0;
        model_res = $urandom;
        model_fl  = 5'($urandom);
      end
    end
  end

  // Monotonic event counters; the main thread works with differences.
  int start_cnt = 0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (bus.alu_start) start_cnt++;
    if (state == 3'd6) wait_cnt++;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] prev_res = '0;
  logic [4:0]  prev_fl = '0;
  bit          in_show = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic press(input logic [15:0] v);
    @(posedge clk); #1;
    sw = v;
    btnC = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 btnC = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    prev_res = '0;
    prev_fl  = '0;
    in_show  = 1'b0;
  endtask

  task automatic wait_show();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state == 3'd7) begin
        seen = 1'b1;
        break;
      end
    end
    check("show_reached", {127'd0, seen}, 128'd1);
  endtask

  function automatic vec_t mk(input logic [15:0] s0, s1, s2, s3, s4, input int lat,
                              input logic [31:0] res, input logic [4:0] fl,
                              input logic [31:0] e_a, e_b, input logic [1:0] e_op,
                              input logic [31:0] e_res, input logic [4:0] e_fl,
                              input logic e_to, input int e_wait);
    vec_t v;
    v.sw = {s4, s3, s2, s1, s0};
    v.lat = lat; v.res = res; v.fl = fl;
    v.e_a = e_a; v.e_b = e_b; v.e_op = e_op;
    v.e_res = e_res; v.e_fl = e_fl; v.e_to = e_to; v.e_wait = e_wait;
    return v;
  endfunction

  // Reference model: what a whole operation must leave behind, from the sequencer rules.
  function automatic vec_t model_vec(input logic [4:0][15:0] s, input int lat,
                                     input logic [31:0] res, input logic [4:0] fl);
    vec_t v;
    bit   captured;
    captured = (lat != 0) && (lat <= TO);
    v.sw = s; v.lat = lat; v.res = res; v.fl = fl;
    v.e_a    = {s[1], s[0]};
    v.e_b    = {s[3], s[2]};
    v.e_op   = s[4][1:0];
    v.e_res  = captured ? res : prev_res;
    v.e_fl   = captured ? fl : prev_fl;
    v.e_to   = !captured;
    v.e_wait = captured ? lat : TO;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input bit wait_press);
    int s0, w0;
    logic [EXP_W-1:0] e;
    if (in_show) begin
      press(16'h0000);
      check("show_to_ld_al", state, 3'd0);
    end
    s0 = start_cnt;
    w0 = wait_cnt;
    exp_q.push_back({v.e_a, v.e_b, v.e_op, v.e_res, v.e_fl, v.e_to});
    cur_lat = v.lat;
    cur_res = v.res;
    cur_fl  = v.fl;
    for (int i = 0; i < 4; i++) begin
      press(v.sw[i]);
      check("ld_state", state, 128'(i + 1));
    end
    press(v.sw[4]);
    if (wait_press) begin
      @(posedge clk); #1;
      sw = 16'hFFFF;
      btnC = 1'b1;
      @(posedge clk); #1 btnC = 1'b0;
    end
    wait_show();
    // Let any late alu_done land inside SHOW before judging the captured values.
    repeat (6) @(posedge clk);
    #1;
    if (wait_press) check("no_queued_press", state, 3'd7);
    e = exp_q.pop_front();
    check("alu_a", bus.alu_a, e[103:72]);
    check("alu_b", bus.alu_b, e[71:40]);
    check("alu_op", bus.alu_op, e[39:38]);
    check("result", result, e[37:6]);
    check("flags", flags, e[5:1]);
    check("timeout_err", timeout_err, e[0]);
    check("start_pulses", 128'(start_cnt - s0), 128'd1);
    check("wait_cycles", 128'(wait_cnt - w0), 128'(v.e_wait));
    check("busy_show", busy, 1'b0);
    prev_res = v.e_res;
    prev_fl  = v.e_fl;
    in_show  = 1'b1;
  endtask

  vec_t tbl[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [4:0][15:0] s;
    int lat;

    tbl[0] = mk(16'h0000, 16'h4060, 16'h0000, 16'h4010, 16'h0000, 3, 32'h40B00000, 5'h00,
                32'h40600000, 32'h40100000, 2'b00, 32'h40B00000, 5'h00, 1'b0, 3);
    tbl[1] = mk(16'h1234, 16'h3F80, 16'h5678, 16'hC000, 16'h0003, 0, 32'h0, 5'h00,
                32'h3F801234, 32'hC0005678, 2'b11, 32'h40B00000, 5'h00, 1'b1, 8);
    tbl[2] = mk(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hFFFE, 8, 32'hC1200000, 5'h10,
                32'hBBBBAAAA, 32'hDDDDCCCC, 2'b10, 32'hC1200000, 5'h10, 1'b0, 8);
    tbl[3] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hABCD, 9, 32'h11111111, 5'h1F,
                32'h00020001, 32'h00040003, 2'b01, 32'hC1200000, 5'h10, 1'b1, 8);
    tbl[4] = mk(16'hFFFF, 16'h7F7F, 16'h8000, 16'h0080, 16'h8002, 1, 32'h3F800000, 5'h01,
                32'h7F7FFFFF, 32'h00808000, 2'b10, 32'h3F800000, 5'h01, 1'b0, 1);

    // Reset values, with the button held through reset release.
    btnC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 3'd0);
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_alu_b", bus.alu_b, 32'h0);
    check("rst_alu_op", bus.alu_op, 2'b00);
    check("rst_start", bus.alu_start, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_flags", flags, 5'h0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("held_btn_state", state, 3'd0);
    check("held_btn_alu_a", bus.alu_a, 32'h0);
    btnC = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    press(16'h1111);
    check("first_press_state", state, 3'd1);
    check("first_press_alu_a", bus.alu_a, 32'h00001111);

    // Spurious alu_done while loading.
    @(posedge clk); #1;
    spur_done = 1'b1;
    spur_res  = 32'hDEADBEEF;
    spur_fl   = 5'h1F;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("spur_state", state, 3'd1);
    check("spur_result", result, 32'h0);
    check("spur_flags", flags, 5'h0);
    check("spur_timeout", timeout_err, 1'b0);
    check("spur_alu_a", bus.alu_a, 32'h00001111);
    do_reset();

    for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0);
    prev_res = 32'h3F800000;
    prev_fl  = 5'h01;

    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < 5; j++) s[j] = 16'($urandom);
      lat = $urandom_range(0, 12);
      v = model_vec(s, lat, $urandom, 5'($urandom_range(0, 31)));
      run_txn(v, 1'b0);
    end

    // Press during WAIT must be dropped, with a timeout outcome.
    v = model_vec({16'h0001, 16'hDEF0, 16'h9ABC, 16'h2468, 16'h1357}, 0, 32'h0, 5'h0);
    run_txn(v, 1'b1);

    // Reset in WAIT; the ALU answer that arrives afterwards must be ignored.
    press(16'h0000);
    check("rw_ld_al", state, 3'd0);
    cur_lat = 12;
    cur_res = 32'h12345678;
    cur_fl  = 5'h0A;
    press(16'h5555);
    press(16'h6666);
    press(16'h7777);
    press(16'h8888);
    press(16'h0002);
    check("rw_busy_in_wait", busy, 1'b1);
    check("rw_state_wait", state, 3'd6);
    #2 reset = 1'b0;
    #1;
    check("rw_async_state", state, 3'd0);
    check("rw_async_alu_a", bus.alu_a, 32'h0);
    #3 reset = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("rw_state", state, 3'd0);
    check("rw_alu_a", bus.alu_a, 32'h0);
    check("rw_alu_b", bus.alu_b, 32'h0);
    check("rw_alu_op", bus.alu_op, 2'b00);
    check("rw_result", result, 32'h0);
    check("rw_flags", flags, 5'h0);
    check("rw_timeout", timeout_err, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_start", bus.alu_start, 1'b0);

`ifdef FPU_SEQ_DEBOUNCE_EN
    @(posedge clk); #1;
    sw = 16'h0BAD;
    btnC = 1'b1;
    repeat (2) @(posedge clk);
    #1 btnC = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("db_glitch_state", state, 3'd0);
    check("db_glitch_alu_a", bus.alu_a, 32'h0);
    press(16'h00AB);
    repeat (8) @(posedge clk);
    #1;
    check("db_press_state", state, 3'd1);
    check("db_press_alu_a", bus.alu_a, 32'h000000AB);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
